// File: rtl/verifica_senha_multi.sv
// verifica_senha_multi: sequential search for any stored password hidden inside a typed digit sequence
//   clk, rst                      : clock, asynchronous active-high reset
//   valid_in                      : one-cycle start request, honoured only in IDLE
//   senha_teste, senhas_reais     : typed digits and stored slots, captured at the request
//   busy, done                    : busy from capture through the one-cycle done pulse
//   senha_ok, match_idx, fail_cnt : result, lowest matching slot, saturating consecutive-fail count
module verifica_senha_multi #(
    parameter int MAX_TESTE  = 20,
    parameter int MAX_REAL   = 12,
    parameter int MIN_LEN    = 4,
    parameter int NUM_SENHAS = 4,
    localparam int IW  = NUM_SENHAS > 1 ? $clog2(NUM_SENHAS) : 1,
    localparam int OW  = MAX_TESTE > 1 ? $clog2(MAX_TESTE) : 1,
    localparam int LTW = $clog2(MAX_TESTE + 1),
    localparam int LRW = $clog2(MAX_REAL + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_in,
    input  logic [4*MAX_TESTE-1:0]           senha_teste,
    input  logic [4*MAX_REAL*NUM_SENHAS-1:0] senhas_reais,
    output logic                             busy,
    output logic                             done,
    output logic                             senha_ok,
    output logic [IW-1:0]                    match_idx,
    output logic [3:0]                       fail_cnt
);
    typedef enum logic [1:0] {IDLE, MEASURE, SEARCH, DONE} state_t;
    state_t                           state;
    logic [4*MAX_TESTE-1:0]           test_q;
    logic [4*MAX_REAL*NUM_SENHAS-1:0] real_q;
    logic [IW-1:0]                    slot;
    logic [OW-1:0]                    off;
    logic [LTW-1:0]                   len_t;
    logic [LRW-1:0]                   len_r, len_r_q;
    logic                             hit, skip, last_slot, last_win;
    // Lengths come from the first 0xF digit, so scanning downwards leaves the lowest one.
    // The window compare guards off+i because only i < len_r_q digits are meaningful.
    always_comb begin
        len_t = LTW'(MAX_TESTE);
        for (int i = MAX_TESTE - 1; i >= 0; i--)
            if (test_q[4*i +: 4] == 4'hF) len_t = LTW'(i);
        len_r = LRW'(MAX_REAL);
        for (int i = MAX_REAL - 1; i >= 0; i--)
            if (real_q[4*(int'(slot)*MAX_REAL+i) +: 4] == 4'hF) len_r = LRW'(i);
        hit = 1'b1;
        for (int i = 0; i < MAX_REAL; i++)
            if (i < int'(len_r_q) && int'(off) + i < MAX_TESTE &&
                real_q[4*(int'(slot)*MAX_REAL+i) +: 4] != test_q[4*(int'(off)+i) +: 4])
                hit = 1'b0;
        skip      = int'(len_r) < MIN_LEN || int'(len_r) > int'(len_t);
        last_slot = int'(slot) == NUM_SENHAS - 1;
        last_win  = int'(off) == int'(len_t) - int'(len_r_q);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            test_q    <= '0;
            real_q    <= '0;
            slot      <= '0;
            off       <= '0;
            len_r_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            senha_ok  <= 1'b0;
            match_idx <= '0;
            fail_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    test_q    <= senha_teste;
                    real_q    <= senhas_reais;
                    slot      <= '0;
                    off       <= '0;
                    busy      <= 1'b1;
                    senha_ok  <= 1'b0;
                    match_idx <= '0;
                    state     <= MEASURE;
                end
                MEASURE: if (skip && last_slot) begin
                    state     <= DONE;
                    done      <= 1'b1;
                    fail_cnt  <= fail_cnt + {3'b0, fail_cnt != 4'hF};
                end else if (skip) begin
                    slot      <= slot + 1'b1;
                end else begin
                    off       <= '0;
                    len_r_q   <= len_r;
                    state     <= SEARCH;
                end
                SEARCH: if (hit) begin
                    state     <= DONE;
                    done      <= 1'b1;
                    senha_ok  <= 1'b1;
                    match_idx <= slot;
                    fail_cnt  <= '0;
                end else if (last_win && last_slot) begin
                    state     <= DONE;
                    done      <= 1'b1;
                    fail_cnt  <= fail_cnt + {3'b0, fail_cnt != 4'hF};
                end else if (last_win) begin
                    slot      <= slot + 1'b1;
                    state     <= MEASURE;
                end else begin
                    off       <= off + 1'b1;
                end
                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_verifica_senha_multi.sv
// tb_verifica_senha_multi: scoreboard bench for verifica_senha_multi with directed vectors
module tb_verifica_senha_multi;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_in = 1'b0;
    logic [79:0]  senha_teste = '1;
    logic [191:0] senhas_reais = '1;
    logic         busy, done, senha_ok;
    logic [1:0]   match_idx;
    logic [3:0]   fail_cnt;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_done = 0;
    typedef struct {
        string name;
        bit    ok;
        int    idx;
        int    fc;
        int    at;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    verifica_senha_multi dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .senha_teste(senha_teste),
        .senhas_reais(senhas_reais), .busy(busy), .done(done), .senha_ok(senha_ok),
        .match_idx(match_idx), .fail_cnt(fail_cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string n, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", n, got, exp);
        end
    endtask
    function automatic logic [3:0] hd(input byte c);
        return (c >= 8'h30 && c <= 8'h39) ? 4'(c - 8'h30) : 4'(c - 8'h41 + 10);
    endfunction
    function automatic logic [79:0] mk_t(input string s);
        logic [79:0] v = '1;
        for (int i = 0; i < s.len(); i++) v[4*i +: 4] = hd(s[i]);
        return v;
    endfunction
    function automatic logic [191:0] mk_r(input string a, input string b, input string c, input string d);
        logic [191:0] v = '1;
        string s[4] = '{a, b, c, d};
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < s[k].len(); i++) v[4*(k*12+i) +: 4] = hd(s[k][i]);
        return v;
    endfunction
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                mon_e = q.pop_front();
                check({mon_e.name, ".senha_ok"}, int'(senha_ok), int'(mon_e.ok));
                check({mon_e.name, ".match_idx"}, int'(match_idx), mon_e.idx);
                check({mon_e.name, ".fail_cnt"}, int'(fail_cnt), mon_e.fc);
                check({mon_e.name, ".done_cycle"}, cyc, mon_e.at);
                check({mon_e.name, ".busy"}, int'(busy), 1);
            end
        end
    end
    // extra: 1-based cycle after capture at which a second valid_in is pulsed (0 = none)
    task automatic run(input string name, input string t, input logic [191:0] r, input bit ok,
                       input int idx, input int fc, input int lat, input int extra, input string alt);
        exp_t e;
        @(negedge clk);
        #1;
        senha_teste  = mk_t(t);
        senhas_reais = r;
        valid_in     = 1'b1;
        e = '{name, ok, idx, fc, cyc + lat};
        q.push_back(e);
        for (int k = 1; k <= lat + 20; k++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && k > extra) break;
            valid_in     = (k + 1 == extra) || (k == 0);
            senha_teste  = (k + 1 == extra) ? mk_t(alt) : '1;
            senhas_reais = (k + 1 == extra) ? r : '1;
        end
        valid_in = 1'b0;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s.timeout: got no done, expected done at cycle %0d", name, e.at);
            q.delete();
        end
    endtask
    logic [191:0] r_1234, r_hid, r_low, r_full, r_short, r_long;
    int nd;
    initial begin
        r_1234  = mk_r("1234", "", "", "");
        r_hid   = mk_r("9999", "", "567890", "");
        r_low   = mk_r("9999", "4321", "", "4321");
        r_full  = mk_r("123456789012", "", "", "");
        r_short = mk_r("123", "", "", "");
        r_long  = mk_r("12345", "", "", "");
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.senha_ok", int'(senha_ok), 0);
        check("reset.match_idx", int'(match_idx), 0);
        check("reset.fail_cnt", int'(fail_cnt), 0);
        run("exact", "1234", r_1234, 1, 0, 0, 3, 0, "");
        run("hidden", "11567890", r_hid, 1, 2, 0, 12, 0, "");
        run("lowest", "4321", r_low, 1, 1, 0, 5, 0, "");
        run("full_len", "00000000123456789012", r_full, 1, 0, 0, 11, 0, "");
        run("invalid", "123", r_short, 0, 0, 1, 5, 0, "");
        run("too_long", "1234", r_long, 0, 0, 2, 5, 0, "");
        for (int n = 3; n <= 16; n++)
            run("wrong", "5678", r_1234, 0, 0, n > 15 ? 15 : n, 6, 0, "");
        run("ignored_busy", "1234", r_1234, 1, 0, 0, 3, 2, "5678");
        run("ignored_done", "5678", r_1234, 0, 0, 1, 6, 6, "1234");
        repeat (10) @(negedge clk);
        #1;
        senha_teste  = mk_t("11567890");
        senhas_reais = r_hid;
        valid_in     = 1'b1;
        @(negedge clk);
        #1 valid_in = 1'b0;
        repeat (4) @(negedge clk);
        check("mid.busy", int'(busy), 1);
        check("mid.fail_cnt", int'(fail_cnt), 1);
        #1 rst = 1'b1;
        #1;
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.senha_ok", int'(senha_ok), 0);
        check("rst.match_idx", int'(match_idx), 0);
        check("rst.fail_cnt", int'(fail_cnt), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        nd = n_done;
        repeat (20) @(negedge clk);
        check("rst.no_done", n_done, nd);
        run("after_rst", "991234", r_1234, 1, 0, 0, 5, 0, "");
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/verifica_senha_multi.md
# verifica_senha_multi

- Verifies a typed digit sequence against `NUM_SENHAS` stored passwords of variable length.
- A stored password matches if it appears contiguously anywhere inside the typed sequence. This lets a user hide the code among extra digits typed before or after it.
- The search is sequential: one window offset per clock. It sits between keypad entry capture and the lock-control FSM.
- Reports which slot matched and keeps a saturating count of consecutive failures.

## Interface
- `MAX_TESTE`, 20: max digits in the typed sequence.
- `MAX_REAL`, 12: max digits per stored password.
- `MIN_LEN`, 4: minimum valid stored-password length.
- `NUM_SENHAS`, 4: number of stored password slots (≥1).
- `clk`  in  1  clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `valid_in`  in  1  one-cycle request to start a verification.
- `senha_teste`  in  4*MAX_TESTE  typed digits. Digit i is `[4i+3:4i]`; 0xF means empty/terminator.
- `senhas_reais`  in  4*MAX_REAL*NUM_SENHAS  stored passwords. Slot s, digit i is at bit `4*(s*MAX_REAL+i)`.
- `busy`  out  1  high from capture until `done`, inclusive.
- `done`  out  1  one-cycle pulse: verification finished.
- `senha_ok`  out  1  1 = some slot matched.
- `match_idx`  out  $clog2(NUM_SENHAS) (min 1)  lowest matching slot; 0 on failure.
- `fail_cnt`  out  4  consecutive failed verifications, saturating at 15.

## Operation
- **States:** IDLE, MEASURE, SEARCH, DONE. All outputs are registered or decoded from state.
- **IDLE:**
  - When `valid_in` is high, capture `senha_teste` and `senhas_reais` into internal registers.
  - Set slot=0 and off=0, then go to MEASURE.
  - Inputs may change after capture.
- **Length rule:** a sequence's length is the index of its first 0xF digit, or its maximum size if there is none. Digits after the first 0xF are ignored.
  - len_t applies to the typed sequence, range 0..MAX_TESTE.
  - len_r applies to the current slot, range 0..MAX_REAL.
- **MEASURE:** computes len_r for the current slot.
  - If len_r < MIN_LEN or len_r > len_t, the slot is skipped: go to the next slot in MEASURE. If it was the last slot, go to DONE with a fail.
  - Otherwise set off=0 and go to SEARCH.
- **SEARCH:** each cycle, the window at offset off matches if real[i]==test[off+i] for all i<len_r.
  - On a match, go to DONE with ok and match_idx=slot.
  - If there is no match and off == len_t−len_r, go to the next slot (MEASURE). If it was the last slot, go to DONE with a fail.
  - Otherwise off += 1.
  - Slots are scanned in ascending order, so the lowest-index match wins.
- **DONE:**
  - `done`=1 for exactly one cycle, then return to IDLE.
  - On ok, `fail_cnt` clears to 0. On fail, `fail_cnt` increments, saturating at 15.
  - `fail_cnt` updates on entry to DONE.
- **Held outputs:** `senha_ok` and `match_idx` are updated on entry to DONE and held until the next capture. At capture they are cleared to 0.
- **Ignored request:** `valid_in` while busy is ignored, with no queueing.
- **Counter width:** off is wide enough for 0..MAX_TESTE−1; slot for 0..NUM_SENHAS−1. No wrap is possible, because the end-of-search comparison uses equality before increment.

## Timing
- **Reset values:** `busy`=0, `done`=0, `senha_ok`=0, `match_idx`=0, `fail_cnt`=0, state=IDLE.
- **Reset mid-operation:** the search aborts immediately and no `done` is issued.
- **Latency:** if `valid_in` is sampled at edge E, a match in slot 0 at offset 0 gives `done` high in the cycle after edge E+2.
- **General latency formula:** `done` rises after 1 + Σ over visited slots of (1 + windows tested) edges, where a skipped slot costs 1 edge.
- **Worst case:** NUM_SENHAS × (1 + MAX_TESTE−MIN_LEN+1) + 1 edges.
- **`busy` timing:** `busy` rises in the cycle after the capturing edge. It stays high through the `done` cycle and falls when the FSM returns to IDLE.
- **Back-to-back requests:** a new `valid_in` is accepted on the first cycle back in IDLE, i.e. the cycle after `done`.
- **Simultaneous events:** `valid_in` coinciding with `done` is ignored. `valid_in` coinciding with `rst` is ignored.

## Test plan
- **Exact match, slot 0:** slot0=1234F…, teste=1234F… → `done` in the cycle after E+2, `senha_ok`=1, `match_idx`=0, `fail_cnt`=0.
- **Hidden match, later slot:** slot0=9999F, slot2=567890F, teste=11567890FF… → `senha_ok`=1 and `match_idx`=2. `done` arrives after the expected edge count: slot0 tests 5 windows (8−4+1); slot1 is all-F and skipped; slot2 hits at off=2.
- **Invalid slots skipped:** slot0=123F (len 3), slot1 all-F, teste=123F → both slots skipped, remaining slots must also miss, result `senha_ok`=0; `fail_cnt` goes from 0 to 1.
- **Fail saturation:** 16 consecutive wrong entries → `fail_cnt` reads 15 after the 15th and 16th. A subsequent correct entry clears it to 0.
- **Full-length boundary:** MAX_REAL-digit slot with no F, teste = that code at off=MAX_TESTE−MAX_REAL → match on the last window tested.
- **Reset and ignored request:** `rst` pulsed mid-SEARCH → all outputs go to 0 and no `done` follows. Separately, `valid_in` pulsed while busy → exactly one `done`, with results from the first capture.
